// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: depth, per-level entry
// counts and the signed saturation bounds.
package adder_tree_pkg;

    function automatic int tree_levels(input int n);
        return $clog2(n);
    endfunction

    function automatic int level_active(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction

    function automatic logic signed [127:0] sat_max(input int w);
        return (128'sd1 <<< (w - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] sat_min(input int w);
        return -(128'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level: pairwise adds, odd entry passes through,
// valid travels with data, everything holds while advance is low.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter  int W           = 32,
    parameter  int ENTRIES_IN  = 2,
    localparam int ENTRIES_OUT = (ENTRIES_IN + 1) / 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              advance,
    input  logic                              in_valid,
    input  logic [ENTRIES_IN-1:0][W-1:0]      in_data,
    output logic                              out_valid,
    output logic [ENTRIES_OUT-1:0][W-1:0]     out_data
);

    logic [ENTRIES_OUT-1:0][W-1:0] pair_sum;
    logic [ENTRIES_OUT-1:0][W-1:0] data_d;
    logic [ENTRIES_OUT-1:0][W-1:0] data_q;
    logic                          valid_d;
    logic                          valid_q;

    for (genvar i = 0; i < ENTRIES_OUT; i++) begin : g_pair
        if (2 * i + 1 < ENTRIES_IN) begin : g_add
            assign pair_sum[i] = in_data[2*i] + in_data[2*i+1];
        end else begin : g_pass
            assign pair_sum[i] = in_data[2*i];
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (advance) begin
            valid_d = in_valid;
            data_d  = pair_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with a global-stall valid/ready handshake.
// Define ADDER_TREE_SAT_EN to clamp out-of-range sums instead of wrapping.
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int N     = 8,
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data [0:N-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_sum,
    output logic                    out_ovf
);

    localparam int LEVELS = tree_levels(N);
    localparam int SUM_W  = IN_W + LEVELS;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(sat_max(OUT_W));
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(sat_min(OUT_W));

    logic                        advance;
    logic                        s0_valid_d;
    logic                        s0_valid_q;
    logic [N-1:0][SUM_W-1:0]     s0_data_d;
    logic [N-1:0][SUM_W-1:0]     s0_data_q;
    logic signed [SUM_W-1:0]     full_sum;
    logic                        too_big;
    logic                        too_small;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_data_d  = s0_data_q;
        if (advance) begin
            s0_valid_d = in_valid;
            for (int i = 0; i < N; i++) begin
                s0_data_d[i] = {{LEVELS{in_data[i][IN_W-1]}}, in_data[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_data_q  <= s0_data_d;
        end
    end

    for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
        localparam int EIN  = level_active(N, g);
        localparam int EOUT = level_active(N, g + 1);

        logic [EIN-1:0][SUM_W-1:0]  d_in;
        logic                       v_in;
        logic [EOUT-1:0][SUM_W-1:0] d_out;
        logic                       v_out;

        if (g == 0) begin : g_first
            assign d_in = s0_data_q;
            assign v_in = s0_valid_q;
        end else begin : g_chain
            assign d_in = g_lvl[g-1].d_out;
            assign v_in = g_lvl[g-1].v_out;
        end

        adder_tree_level #(
            .W          (SUM_W),
            .ENTRIES_IN (EIN)
        ) u_level (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance),
            .in_valid  (v_in),
            .in_data   (d_in),
            .out_valid (v_out),
            .out_data  (d_out)
        );
    end

    assign full_sum  = g_lvl[LEVELS-1].d_out[0];
    assign out_valid = g_lvl[LEVELS-1].v_out;
    assign too_big   = full_sum > SUM_MAX;
    assign too_small = full_sum < SUM_MIN;

    always_comb begin
        out_ovf = out_valid & (too_big | too_small);
`ifdef ADDER_TREE_SAT_EN
        if (too_big) begin
            out_sum = SUM_MAX[OUT_W-1:0];
        end else if (too_small) begin
            out_sum = SUM_MIN[OUT_W-1:0];
        end else begin
            out_sum = full_sum[OUT_W-1:0];
        end
`else
        out_sum = full_sum[OUT_W-1:0];
`endif
    end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree: N=8 streaming scoreboard plus
// directed N=5 and N=4/16-bit instances.
module tb_pipelined_adder_tree;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic signed [31:0] a_in_data [0:7];
    logic signed [31:0] a_out_sum;

    logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic signed [31:0] b_in_data [0:4];
    logic signed [31:0] b_out_sum;

    logic               c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
    logic signed [15:0] c_in_data [0:3];
    logic signed [15:0] c_out_sum;

    pipelined_adder_tree #(.N(8), .IN_W(32), .OUT_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_ovf(a_out_ovf)
    );

    pipelined_adder_tree #(.N(5), .IN_W(32), .OUT_W(32)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_ovf(b_out_ovf)
    );

    pipelined_adder_tree #(.N(4), .IN_W(16), .OUT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_sum(c_out_sum), .out_ovf(c_out_ovf)
    );

`ifdef ADDER_TREE_SAT_EN
    localparam logic [31:0] C_POS = 32'h0000_7FFF;
    localparam logic [31:0] C_NEG = 32'h0000_8000;
    localparam logic [31:0] A_BIG = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] C_POS = 32'h0000_FFFC;
    localparam logic [31:0] C_NEG = 32'h0000_0000;
    localparam logic [31:0] A_BIG = 32'hFFFF_FFF8;
`endif

    longint MAXV = 64'sd2147483647;
    longint MINV = -64'sd2147483648;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Expected 32-bit result from the exact mathematical sum.
    function automatic logic [31:0] exp_sum32(input longint s);
        logic [63:0] t;
        t = s;
`ifdef ADDER_TREE_SAT_EN
        if (s > MAXV) return 32'h7FFF_FFFF;
        if (s < MINV) return 32'h8000_0000;
`endif
        return t[31:0];
    endfunction

    function automatic logic exp_ovf32(input longint s);
        return (s > MAXV) || (s < MINV);
    endfunction

    longint exp_q[$];
    bit          held = 1'b0;
    logic [31:0] held_sum;
    logic        held_ovf;

    always @(negedge clk) begin
        longint s;
        if (!rst_n) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", {31'b0, a_out_valid}, 32'd1);
                chk("hold_sum", a_out_sum, held_sum);
                chk("hold_ovf", {31'b0, a_out_ovf}, {31'b0, held_ovf});
            end
            if (a_out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=0x%0h required=none", a_out_sum);
                end else begin
                    chk("stream_sum", a_out_sum, exp_sum32(exp_q[0]));
                    chk("stream_ovf", {31'b0, a_out_ovf}, {31'b0, exp_ovf32(exp_q[0])});
                    if (a_out_ready) void'(exp_q.pop_front());
                end
            end
            held     = a_out_valid && !a_out_ready;
            held_sum = a_out_sum;
            held_ovf = a_out_ovf;
            if (a_in_valid && a_in_ready) begin
                s = 0;
                for (int i = 0; i < 8; i++) s += longint'(a_in_data[i]);
                exp_q.push_back(s);
            end
        end
    end

    // Presents one vector to all three instances and records each latency.
    task automatic run_directed(input string nm,
                                input logic [31:0] a_req, input logic a_ovf,
                                input logic [31:0] b_req,
                                input logic [31:0] c_req, input logic c_ovf);
        int la = 0, lb = 0, lc = 0;
        logic [31:0] sa = '0, sb = '0, sc = '0;
        logic oa = 1'b0, ob = 1'b0, oc = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        b_in_valid = 1'b1;
        c_in_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, {31'b0, a_in_ready}, 32'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (a_out_valid && la == 0) begin la = k; sa = a_out_sum; oa = a_out_ovf; end
            if (b_out_valid && lb == 0) begin lb = k; sb = b_out_sum; ob = b_out_ovf; end
            if (c_out_valid && lc == 0) begin lc = k; sc = {16'h0, c_out_sum}; oc = c_out_ovf; end
            @(posedge clk); #1;
        end
        chk({nm, "_a_lat"}, la, 32'd4);
        chk({nm, "_a_sum"}, sa, a_req);
        chk({nm, "_a_ovf"}, {31'b0, oa}, {31'b0, a_ovf});
        chk({nm, "_b_lat"}, lb, 32'd4);
        chk({nm, "_b_sum"}, sb, b_req);
        chk({nm, "_b_ovf"}, {31'b0, ob}, 32'd0);
        chk({nm, "_c_lat"}, lc, 32'd3);
        chk({nm, "_c_sum"}, sc, c_req);
        chk({nm, "_c_ovf"}, {31'b0, oc}, {31'b0, c_ovf});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int seen;
        int w;
        bit done;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        c_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        b_out_ready = 1'b1;
        c_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) a_in_data[i] = '0;
        for (int i = 0; i < 5; i++) b_in_data[i] = '0;
        for (int i = 0; i < 4; i++) c_in_data[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
        chk("rst_out_sum", a_out_sum, 32'd0);
        chk("rst_out_ovf", {31'b0, a_out_ovf}, 32'd0);
        chk("rst_in_ready", {31'b0, a_in_ready}, 32'd1);
        chk("rst_c_out_sum", {16'h0, c_out_sum}, 32'd0);
        a_out_ready = 1'b1;
        #3 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) a_in_data[i] = 32'(i + 1);
        b_in_data = '{-3, 7, 10, -20, 100};
        for (int i = 0; i < 4; i++) c_in_data[i] = 16'sh7FFF;
        run_directed("d1", 32'd36, 1'b0, 32'd94, C_POS, 1'b1);

        for (int i = 0; i < 8; i++) a_in_data[i] = 32'sh7FFF_FFFF;
        b_in_data = '{1, 2, 3, 4, 5};
        for (int i = 0; i < 4; i++) c_in_data[i] = -16'sd32768;
        run_directed("d2", A_BIG, 1'b1, 32'd15, C_NEG, 1'b1);

        for (int v = 0; v < 20; v++) begin
            if ($urandom_range(0, 3) == 0) begin
                a_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            for (int i = 0; i < 8; i++) a_in_data[i] = $signed($urandom);
            a_in_valid = 1'b1;
            done = 1'b0;
            w = 0;
            while (!done && w < 50) begin
                @(negedge clk);
                done = a_in_ready;
                @(posedge clk); #1;
                a_out_ready = 1'($urandom_range(0, 1));
                w++;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL stream_accept actual=timeout required=transfer");
            end
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) a_in_data[i] = 32'(k + 1);
            a_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", {31'b0, a_out_valid}, 32'd1);
        chk("pre_rst_sum", a_out_sum, 32'd8);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, a_out_valid}, 32'd0);
        chk("mid_rst_sum", a_out_sum, 32'd0);
        chk("mid_rst_ovf", {31'b0, a_out_ovf}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, a_in_ready}, 32'd1);
        @(posedge clk); #3 rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_out_valid) seen++;
        end
        chk("no_ghost", seen, 32'd0);

        for (int i = 0; i < 8; i++) a_in_data[i] = 32'd2;
        for (int i = 0; i < 5; i++) b_in_data[i] = -32'sd1;
        c_in_data = '{16'sd100, -16'sd50, 16'sd25, -16'sd75};
        run_directed("d3", 32'd16, 1'b0, 32'hFFFF_FFFB, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
